// File: rtl/cpu_define.sv
// cpu_define: definitions shared by the decode slice.
//   - micro-op codes (op_e), including OP_ILLEGAL
//   - RV32I major opcode constants
//   - dispatch unit select encoding (RS / LSB)
//   - TagBus / OPBus / RegBus default widths
package cpu_define;

  localparam int TagBus = 4;
  localparam int OPBus  = 6;
  localparam int RegBus = 5;

  // Dispatch target unit
  localparam logic UNIT_RS  = 1'b0;  // ALU / branch / jump reservation station
  localparam logic UNIT_LSB = 1'b1;  // load-store buffer

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Micro-op codes. OP_NOP (0) is the reset value of the dispatch register.
  typedef enum logic [OPBus-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ILLEGAL
  } op_e;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I decoder.
//   inst                 in  32-bit instruction word
//   op                   out micro-op code (OP_ILLEGAL for unknown encodings)
//   unit                 out 0 = RS, 1 = LSB
//   imm                  out extended immediate (0 for R-type and illegal)
//   rs1_use/rs2_use/rd_use out operand required flags
//   rs1_addr/rs2_addr/rd_addr out raw register fields of inst
//   illegal              out unknown opcode/funct3/funct7 combination
module decode_comb
  import cpu_define::*;
#(
  parameter int OP_WIDTH       = OPBus,
  parameter int REG_ADDR_WIDTH = RegBus
) (
  input  logic [31:0]               inst,
  output logic [OP_WIDTH-1:0]       op,
  output logic                      unit,
  output logic [31:0]               imm,
  output logic                      rs1_use,
  output logic                      rs2_use,
  output logic                      rd_use,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      illegal
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  op_e         op_d;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  assign rs1_addr = REG_ADDR_WIDTH'(inst[19:15]);
  assign rs2_addr = REG_ADDR_WIDTH'(inst[24:20]);
  assign rd_addr  = REG_ADDR_WIDTH'(inst[11:7]);
  assign op       = OP_WIDTH'(op_d);

  always_comb begin
    // Anything not matched below stays OP_ILLEGAL.
    op_d    = OP_ILLEGAL;
    unit    = UNIT_RS;
    imm     = 32'b0;
    rs1_use = 1'b1;
    rs2_use = 1'b0;
    rd_use  = 1'b1;
    illegal = 1'b0;

    case (inst[6:0])
      OPC_LUI: begin
        op_d = OP_LUI; imm = imm_u; rs1_use = 1'b0;
      end
      OPC_AUIPC: begin
        op_d = OP_AUIPC; imm = imm_u; rs1_use = 1'b0;
      end
      OPC_JAL: begin
        op_d = OP_JAL; imm = imm_j; rs1_use = 1'b0;
      end
      OPC_JALR: begin
        if (f3 == 3'd0) op_d = OP_JALR;
        imm = imm_i;
      end
      OPC_BRANCH: begin
        case (f3)
          3'd0: op_d = OP_BEQ;
          3'd1: op_d = OP_BNE;
          3'd4: op_d = OP_BLT;
          3'd5: op_d = OP_BGE;
          3'd6: op_d = OP_BLTU;
          3'd7: op_d = OP_BGEU;
          default: ;
        endcase
        imm = imm_b; rs2_use = 1'b1; rd_use = 1'b0;
      end
      OPC_LOAD: begin
        case (f3)
          3'd0: op_d = OP_LB;
          3'd1: op_d = OP_LH;
          3'd2: op_d = OP_LW;
          3'd4: op_d = OP_LBU;
          3'd5: op_d = OP_LHU;
          default: ;
        endcase
        unit = UNIT_LSB; imm = imm_i;
      end
      OPC_STORE: begin
        case (f3)
          3'd0: op_d = OP_SB;
          3'd1: op_d = OP_SH;
          3'd2: op_d = OP_SW;
          default: ;
        endcase
        unit = UNIT_LSB; imm = imm_s; rs2_use = 1'b1; rd_use = 1'b0;
      end
      OPC_OPIMM: begin
        imm = imm_i;
        case (f3)
          3'd0: op_d = OP_ADDI;
          3'd2: op_d = OP_SLTI;
          3'd3: op_d = OP_SLTIU;
          3'd4: op_d = OP_XORI;
          3'd6: op_d = OP_ORI;
          3'd7: op_d = OP_ANDI;
          3'd1: begin
            imm = imm_sh;
            if (f7 == 7'h00) op_d = OP_SLLI;
          end
          3'd5: begin
            imm = imm_sh;
            if (f7 == 7'h00)      op_d = OP_SRLI;
            else if (f7 == 7'h20) op_d = OP_SRAI;
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        rs2_use = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: op_d = OP_ADD;
          {7'h20, 3'd0}: op_d = OP_SUB;
          {7'h00, 3'd1}: op_d = OP_SLL;
          {7'h00, 3'd2}: op_d = OP_SLT;
          {7'h00, 3'd3}: op_d = OP_SLTU;
          {7'h00, 3'd4}: op_d = OP_XOR;
          {7'h00, 3'd5}: op_d = OP_SRL;
          {7'h20, 3'd5}: op_d = OP_SRA;
          {7'h00, 3'd6}: op_d = OP_OR;
          {7'h00, 3'd7}: op_d = OP_AND;
          default: ;
        endcase
      end
      default: ;
    endcase

    // Illegal micro-ops carry no operands so the RS never waits on them.
    if (op_d == OP_ILLEGAL) begin
      illegal = 1'b1;
      unit    = UNIT_RS;
      imm     = 32'b0;
      rs1_use = 1'b0;
      rs2_use = 1'b0;
      rd_use  = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between instruction queue and
// dispatch. Decodes one instruction per cycle, allocates a ROB tag, issues
// the rename write, and holds the micro-op until the target unit accepts it.
//   clk, rst (async, active-low), rdy (global enable), flush
//   iq_valid/iq_inst/iq_pc in, iq_ready out (pop strobe)
//   rob_full/rob_tag in, rob_alloc out
//   rf_rename_en/addr/tag out (same-cycle rename of rd)
//   rs_ready/lsb_ready in; disp_* out (registered micro-op)
// Optional: define ID_ILLEGAL_TRAP_EN to dispatch illegal instructions as
// OP_ILLEGAL with a ROB tag; otherwise they are popped and dropped.
module decode_stage
  import cpu_define::*;
#(
  parameter int TAG_WIDTH      = TagBus,
  parameter int OP_WIDTH       = OPBus,
  parameter int REG_ADDR_WIDTH = RegBus
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      iq_valid,
  input  logic [31:0]               iq_inst,
  input  logic [31:0]               iq_pc,
  output logic                      iq_ready,
  input  logic                      rob_full,
  input  logic [TAG_WIDTH-1:0]      rob_tag,
  output logic                      rob_alloc,
  output logic                      rf_rename_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_rename_addr,
  output logic [TAG_WIDTH-1:0]      rf_rename_tag,
  input  logic                      rs_ready,
  input  logic                      lsb_ready,
  output logic                      disp_valid,
  output logic                      disp_unit,
  output logic [OP_WIDTH-1:0]       disp_op,
  output logic [31:0]               disp_imm,
  output logic [31:0]               disp_pc,
  output logic [TAG_WIDTH-1:0]      disp_tag,
  output logic [REG_ADDR_WIDTH-1:0] disp_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] disp_rs2_addr,
  output logic                      disp_rs1_use,
  output logic                      disp_rs2_use,
  output logic [REG_ADDR_WIDTH-1:0] disp_rd_addr,
  output logic                      disp_rd_use
);

  // Decoded fields of the instruction at the head of the queue
  logic [OP_WIDTH-1:0]       dec_op;
  logic                      dec_unit;
  logic [31:0]               dec_imm;
  logic                      dec_rs1_use, dec_rs2_use, dec_rd_use;
  logic [REG_ADDR_WIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic                      dec_illegal;

  decode_comb #(
    .OP_WIDTH       (OP_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode_comb (
    .inst     (iq_inst),
    .op       (dec_op),
    .unit     (dec_unit),
    .imm      (dec_imm),
    .rs1_use  (dec_rs1_use),
    .rs2_use  (dec_rs2_use),
    .rd_use   (dec_rd_use),
    .rs1_addr (dec_rs1),
    .rs2_addr (dec_rs2),
    .rd_addr  (dec_rd),
    .illegal  (dec_illegal)
  );

  // Output register
  logic                      disp_valid_reg;
  logic                      disp_unit_reg;
  logic [OP_WIDTH-1:0]       disp_op_reg;
  logic [31:0]               disp_imm_reg;
  logic [31:0]               disp_pc_reg;
  logic [TAG_WIDTH-1:0]      disp_tag_reg;
  logic [REG_ADDR_WIDTH-1:0] disp_rs1_reg, disp_rs2_reg, disp_rd_reg;
  logic                      disp_rs1_use_reg, disp_rs2_use_reg, disp_rd_use_reg;

  logic fire, slot_free, pop_ok, capture;

  assign fire      = disp_valid_reg & (disp_unit_reg ? lsb_ready : rs_ready);
  assign slot_free = ~disp_valid_reg | fire;
  // rst participates so every strobe is held low while reset is asserted.
  assign pop_ok    = rst & rdy & iq_valid & ~flush;

`ifdef ID_ILLEGAL_TRAP_EN
  // Illegal instructions flow through like any other micro-op.
  assign capture  = pop_ok & ~rob_full & slot_free;
  assign iq_ready = capture;
`else
  // Illegal instructions are discarded from the queue without waiting on the
  // ROB or the output register, since they consume neither.
  assign capture  = pop_ok & ~rob_full & slot_free & ~dec_illegal;
  assign iq_ready = capture | (pop_ok & dec_illegal);
`endif

  assign rob_alloc      = capture;
  assign rf_rename_en   = capture & dec_rd_use & (dec_rd != '0);
  assign rf_rename_addr = dec_rd;
  assign rf_rename_tag  = rob_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid_reg   <= 1'b0;
      disp_unit_reg    <= 1'b0;
      disp_op_reg      <= '0;
      disp_imm_reg     <= '0;
      disp_pc_reg      <= '0;
      disp_tag_reg     <= '0;
      disp_rs1_reg     <= '0;
      disp_rs2_reg     <= '0;
      disp_rd_reg      <= '0;
      disp_rs1_use_reg <= 1'b0;
      disp_rs2_use_reg <= 1'b0;
      disp_rd_use_reg  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        disp_valid_reg <= 1'b0;
      end else if (capture) begin
        disp_valid_reg   <= 1'b1;
        disp_unit_reg    <= dec_unit;
        disp_op_reg      <= dec_op;
        disp_imm_reg     <= dec_imm;
        disp_pc_reg      <= iq_pc;
        disp_tag_reg     <= rob_tag;
        disp_rs1_reg     <= dec_rs1;
        disp_rs2_reg     <= dec_rs2;
        disp_rd_reg      <= dec_rd;
        disp_rs1_use_reg <= dec_rs1_use;
        disp_rs2_use_reg <= dec_rs2_use;
        disp_rd_use_reg  <= dec_rd_use;
      end else if (fire) begin
        disp_valid_reg <= 1'b0;
      end
    end
  end

  assign disp_valid    = disp_valid_reg;
  assign disp_unit     = disp_unit_reg;
  assign disp_op       = disp_op_reg;
  assign disp_imm      = disp_imm_reg;
  assign disp_pc       = disp_pc_reg;
  assign disp_tag      = disp_tag_reg;
  assign disp_rs1_addr = disp_rs1_reg;
  assign disp_rs2_addr = disp_rs2_reg;
  assign disp_rd_addr  = disp_rd_reg;
  assign disp_rs1_use  = disp_rs1_use_reg;
  assign disp_rs2_use  = disp_rs2_use_reg;
  assign disp_rd_use   = disp_rd_use_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed test-plan cases followed by randomized traffic,
// checked against a table-driven reference decoder and a transaction-level
// model of the output register.
module tb_decode_stage;
  import cpu_define::*;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst, rdy, flush, iq_valid, rob_full, rs_ready, lsb_ready;
  logic [31:0] iq_inst, iq_pc;
  logic [3:0]  rob_tag;
  logic        iq_ready, rob_alloc, rf_rename_en;
  logic [4:0]  rf_rename_addr;
  logic [3:0]  rf_rename_tag;
  logic        disp_valid, disp_unit, disp_rs1_use, disp_rs2_use, disp_rd_use;
  logic [5:0]  disp_op;
  logic [31:0] disp_imm, disp_pc;
  logic [3:0]  disp_tag;
  logic [4:0]  disp_rs1_addr, disp_rs2_addr, disp_rd_addr;

  decode_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
    .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .rf_rename_en(rf_rename_en), .rf_rename_addr(rf_rename_addr),
    .rf_rename_tag(rf_rename_tag),
    .rs_ready(rs_ready), .lsb_ready(lsb_ready),
    .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_op(disp_op),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .disp_rs1_addr(disp_rs1_addr), .disp_rs2_addr(disp_rs2_addr),
    .disp_rs1_use(disp_rs1_use), .disp_rs2_use(disp_rs2_use),
    .disp_rd_addr(disp_rd_addr), .disp_rd_use(disp_rd_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference decoder (encoding table) ----------------
  typedef struct {
    logic [6:0] opc;
    int         f3;   // -1 = don't care
    int         f7;   // -1 = don't care
    logic [5:0] op;
    byte        fmt;  // I S B U J R, H = shift-immediate
  } ent_t;
  ent_t tbl[$];

  function automatic void add(logic [6:0] opc, int f3, int f7, logic [5:0] op, byte fmt);
    tbl.push_back('{opc, f3, f7, op, fmt});
  endfunction

  typedef struct packed {
    logic        ill;
    logic [5:0]  op;
    logic        unit;
    logic [31:0] imm;
    logic        u1, u2, ud;
    logic [4:0]  rs1, rs2, rd;
  } ref_t;

  function automatic logic [31:0] imm_of(logic [31:0] i, byte fmt);
    case (fmt)
      "I": return {{20{i[31]}}, i[31:20]};
      "S": return {{20{i[31]}}, i[31:25], i[11:7]};
      "B": return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      "U": return {i[31:12], 12'b0};
      "J": return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      "H": return {27'b0, i[24:20]};
      default: return 32'b0;
    endcase
  endfunction

  function automatic ref_t ref_decode(logic [31:0] i);
    ref_t r;
    r = '0;
    r.ill = 1'b1;
    r.op  = OP_ILLEGAL;
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.rd  = i[11:7];
    foreach (tbl[k]) begin
      if (r.ill && tbl[k].opc == i[6:0] &&
          (tbl[k].f3 < 0 || tbl[k].f3 == int'(i[14:12])) &&
          (tbl[k].f7 < 0 || tbl[k].f7 == int'(i[31:25]))) begin
        r.ill  = 1'b0;
        r.op   = tbl[k].op;
        r.unit = (tbl[k].opc == OPC_LOAD) || (tbl[k].opc == OPC_STORE);
        r.imm  = imm_of(i, tbl[k].fmt);
        r.u1   = !(tbl[k].fmt == "U" || tbl[k].fmt == "J");
        r.u2   = (tbl[k].fmt == "R" || tbl[k].fmt == "S" || tbl[k].fmt == "B");
        r.ud   = !(tbl[k].fmt == "S" || tbl[k].fmt == "B");
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    if ($urandom_range(7) == 0) return w;
    k = $urandom_range(tbl.size() - 1);
    w[6:0] = tbl[k].opc;
    if (tbl[k].f3 >= 0) w[14:12] = tbl[k].f3[2:0];
    if (tbl[k].f7 >= 0) w[31:25] = tbl[k].f7[6:0];
    return w;
  endfunction

  // ---------------- output register model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic        unit;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ud;
  } disp_t;

  logic  exp_v;
  disp_t exp_d;

  function automatic disp_t dut_disp();
    return {disp_op, disp_unit, disp_imm, disp_pc, disp_tag, disp_rs1_addr,
            disp_rs2_addr, disp_rd_addr, disp_rs1_use, disp_rs2_use, disp_rd_use};
  endfunction

  // One clock: inputs already driven after a falling edge.
  task automatic step();
    ref_t  d;
    disp_t nd;
    logic  fire, base, cap, pop, ren, nv;
    #1;
    d    = ref_decode(iq_inst);
    fire = exp_v && (exp_d.unit ? lsb_ready : rs_ready);
    base = rdy && iq_valid && !flush;
    cap  = base && !rob_full && (!exp_v || fire) && (TRAP || !d.ill);
    pop  = cap || (base && d.ill && !TRAP);
    ren  = cap && d.ud && (d.rd != 5'd0);
    check("iq_ready", iq_ready, pop);
    check("rob_alloc", rob_alloc, cap);
    check("rename_en", rf_rename_en, ren);
    check("rename_addr", rf_rename_addr, d.rd);
    check("rename_tag", rf_rename_tag, rob_tag);
    nv = exp_v;
    nd = exp_d;
    if (rdy) begin
      if (flush) nv = 1'b0;
      else if (cap) begin
        nv = 1'b1;
        nd = '{op: d.op, unit: d.unit, imm: d.imm, pc: iq_pc, tag: rob_tag,
               rs1: d.rs1, rs2: d.rs2, rd: d.rd, u1: d.u1, u2: d.u2, ud: d.ud};
      end else if (fire) nv = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_v = nv;
    exp_d = nd;
    check("disp_valid", disp_valid, exp_v);
    check("disp_fields", dut_disp(), exp_d);
    $display("cyc inst=%h tag=%0d pop=%0d alloc=%0d disp_v=%0d op=%0d", iq_inst, rob_tag,
             pop, cap, disp_valid, disp_op);
    @(negedge clk);
  endtask

  task automatic drive(logic [31:0] inst, logic [3:0] tag);
    iq_valid = 1'b1;
    iq_inst  = inst;
    iq_pc    = iq_pc + 32'd4;
    rob_tag  = tag;
  endtask

  initial begin
    add(OPC_LUI, -1, -1, OP_LUI, "U");     add(OPC_AUIPC, -1, -1, OP_AUIPC, "U");
    add(OPC_JAL, -1, -1, OP_JAL, "J");     add(OPC_JALR, 0, -1, OP_JALR, "I");
    add(OPC_BRANCH, 0, -1, OP_BEQ, "B");   add(OPC_BRANCH, 1, -1, OP_BNE, "B");
    add(OPC_BRANCH, 4, -1, OP_BLT, "B");   add(OPC_BRANCH, 5, -1, OP_BGE, "B");
    add(OPC_BRANCH, 6, -1, OP_BLTU, "B");  add(OPC_BRANCH, 7, -1, OP_BGEU, "B");
    add(OPC_LOAD, 0, -1, OP_LB, "I");      add(OPC_LOAD, 1, -1, OP_LH, "I");
    add(OPC_LOAD, 2, -1, OP_LW, "I");      add(OPC_LOAD, 4, -1, OP_LBU, "I");
    add(OPC_LOAD, 5, -1, OP_LHU, "I");     add(OPC_STORE, 0, -1, OP_SB, "S");
    add(OPC_STORE, 1, -1, OP_SH, "S");     add(OPC_STORE, 2, -1, OP_SW, "S");
    add(OPC_OPIMM, 0, -1, OP_ADDI, "I");   add(OPC_OPIMM, 2, -1, OP_SLTI, "I");
    add(OPC_OPIMM, 3, -1, OP_SLTIU, "I");  add(OPC_OPIMM, 4, -1, OP_XORI, "I");
    add(OPC_OPIMM, 6, -1, OP_ORI, "I");    add(OPC_OPIMM, 7, -1, OP_ANDI, "I");
    add(OPC_OPIMM, 1, 0, OP_SLLI, "H");    add(OPC_OPIMM, 5, 0, OP_SRLI, "H");
    add(OPC_OPIMM, 5, 32, OP_SRAI, "H");   add(OPC_OP, 0, 0, OP_ADD, "R");
    add(OPC_OP, 0, 32, OP_SUB, "R");       add(OPC_OP, 1, 0, OP_SLL, "R");
    add(OPC_OP, 2, 0, OP_SLT, "R");        add(OPC_OP, 3, 0, OP_SLTU, "R");
    add(OPC_OP, 4, 0, OP_XOR, "R");        add(OPC_OP, 5, 0, OP_SRL, "R");
    add(OPC_OP, 5, 32, OP_SRA, "R");       add(OPC_OP, 6, 0, OP_OR, "R");
    add(OPC_OP, 7, 0, OP_AND, "R");

    // Reset: strobes low and register cleared even with a pending instruction
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; rob_full = 1'b0;
    rs_ready = 1'b1; lsb_ready = 1'b1; iq_pc = 32'h100; rob_tag = 4'd3;
    iq_valid = 1'b1; iq_inst = 32'h00500093;
    exp_v = 1'b0; exp_d = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_iq_ready", iq_ready, 1'b0);
    check("rst_rob_alloc", rob_alloc, 1'b0);
    check("rst_rename_en", rf_rename_en, 1'b0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_disp_fields", dut_disp(), '0);
    @(negedge clk);
    rst = 1'b1;

    // addi x1,x0,5 with tag 3
    drive(32'h00500093, 4'd3);
    #1 check("addi_rename_en", rf_rename_en, 1'b1);
    check("addi_rename_addr", rf_rename_addr, 5'd1);
    step();
    check("addi_op", disp_op, OP_ADDI);
    check("addi_imm", disp_imm, 32'd5);
    check("addi_unit", disp_unit, 1'b0);
    check("addi_tag", disp_tag, 4'd3);

    // sw x2,8(x1)
    drive(32'h0020A423, 4'd4);
    #1 check("sw_rename_en", rf_rename_en, 1'b0);
    step();
    check("sw_unit", disp_unit, 1'b1);
    check("sw_imm", disp_imm, 32'd8);
    check("sw_regs", {disp_rs1_addr, disp_rs2_addr, disp_rd_use}, {5'd1, 5'd2, 1'b0});

    // beq x0,x0,-4
    drive(32'hFE000EE3, 4'd5);
    step();
    check("beq_imm", disp_imm, 32'hFFFFFFFC);
    check("beq_rs2_use", disp_rs2_use, 1'b1);
    check("beq_unit", disp_unit, 1'b0);

    // Backpressure on the RS: held beq must stay put
    rs_ready = 1'b0;
    drive(32'h00500093, 4'd6);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_iq_ready", iq_ready, 1'b0);
      check("bp_rob_alloc", rob_alloc, 1'b0);
      step();
      check("bp_tag_hold", disp_tag, 4'd5);
    end
    rs_ready = 1'b1;
    #1 check("bp_release_pop", iq_ready, 1'b1);
    step();
    check("bp_next_tag", disp_tag, 4'd6);

    // ROB full stall
    rob_full = 1'b1;
    drive(32'h00100113, 4'd7);
    #1 check("robfull_pop", iq_ready, 1'b0);
    step();
    rob_full = 1'b0;
    step();
    check("pre_flush_valid", disp_valid, 1'b1);

    // Flush while holding a micro-op
    rs_ready = 1'b0; flush = 1'b1;
    drive(32'h00200193, 4'd8);
    #1 check("flush_alloc", rob_alloc, 1'b0);
    step();
    check("flush_valid", disp_valid, 1'b0);
    flush = 1'b0; rs_ready = 1'b1;

    // Illegal instruction
    drive(32'hFFFFFFFF, 4'd9);
    #1 check("ill_pop", iq_ready, 1'b1);
    check("ill_alloc", rob_alloc, TRAP);
    step();
    check("ill_valid", disp_valid, TRAP);
    if (TRAP) check("ill_op", disp_op, OP_ILLEGAL);

    // Randomized traffic, with one asynchronous reset mid-run
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rdy = 1'b1; iq_valid = 1'b1; flush = 1'b0; rob_full = 1'b0;
        rst = 1'b0;
        #1;
        exp_v = 1'b0; exp_d = '0;
        check("midrst_valid", disp_valid, 1'b0);
        check("midrst_fields", dut_disp(), '0);
        check("midrst_pop", iq_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
      end
      rdy       = ($urandom_range(9) != 0);
      flush     = ($urandom_range(19) == 0);
      iq_valid  = ($urandom_range(4) != 0);
      rob_full  = ($urandom_range(6) == 0);
      rs_ready  = ($urandom_range(9) < 7);
      lsb_ready = ($urandom_range(9) < 7);
      iq_inst   = rand_inst();
      iq_pc     = $urandom;
      rob_tag   = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
